sd_spi_master: RTL

- Hardware SPI byte engine for the SD card slot; replaces the CPU bit-banged SD_CMD/SD_CLK/SD_DAT logic behind the F700h I/O window.
- The CPU writes a byte. The block shifts it out MSB-first on MOSI and simultaneously captures 8 bits from MISO. The result is exposed through a small register file.
- Sits between the CPU bus decode (adr, data, we_n, oe_n) and the SD_CLK/SD_CMD/SD_DAT3/SD_DAT pads. Runs on clk64.

---
 rtl/sd_spi_pkg.sv | 17 +
 rtl/sd_spi_tick.sv | 27 ++
 rtl/sd_spi_master.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sd_spi_pkg.sv
// Shared register map, FSM encodings and CTRL bit positions for the SD card SPI byte engine.
package sd_spi_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int CTRL_CS   = 0;
  localparam int CTRL_FAST = 1;

endpackage

// File: rtl/sd_spi_tick.sv
// Loadable half-period down-counter: load sets div-1, tick is high while the count sits at zero.
// Zero latency from count to tick; no backpressure, the owner reloads on every tick it consumes.
module sd_spi_tick #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div - DIVW'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - DIVW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte engine with CTRL/DATA/STATUS registers; a byte takes 16*DIV cycles, busy meanwhile.
// No backpressure: a DATA write while a transfer (including its DONE cycle) is active is dropped and flagged as overrun.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int DIV_SLOW = 80,
  parameter int DIV_FAST = 2,
  parameter int DIVW     = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] sel,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       sd_cs_n,
  output logic       sd_clk,
  output logic       sd_mosi,
  input  logic       sd_miso
);

  logic [1:0]      state;
  logic            ctrl_cs;
  logic            ctrl_fast;
  logic            overrun;
  logic [6:0]      tx_sr;
  logic [7:0]      rx_sr;
  logic [7:0]      rx_reg;
  logic [2:0]      bit_cnt;
  logic            last_bit;
  logic            miso_s1;
  logic            miso_s2;
  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] div_sel;
  logic [DIVW-1:0] div_ld;
  logic            tick;
  logic            tick_load;
  logic            wr_data;
  logic            start;
  logic            shifting;

  assign wr_data   = wr && (sel == REG_DATA);
  assign start     = wr_data && (state == ST_IDLE);
  assign shifting  = (state == ST_LOW) || (state == ST_HIGH);
  assign busy      = shifting;
  assign sd_cs_n   = ~ctrl_cs;
  assign div_sel   = ctrl_fast ? DIVW'(DIV_FAST) : DIVW'(DIV_SLOW);
  assign div_ld    = start ? div_sel : div_q;
  assign tick_load = start || (shifting && tick);

  sd_spi_tick #(
    .DIVW (DIVW)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tick_load),
    .div     (div_ld),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_s1 <= 1'b1;
      miso_s2 <= 1'b1;
    end else begin
      miso_s1 <= sd_miso;
      miso_s2 <= miso_s1;
    end
  end

  // rx_reg only moves on the HIGH->DONE edge, so an aborted byte never becomes visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      sd_clk   <= 1'b0;
      sd_mosi  <= 1'b1;
      tx_sr    <= '0;
      rx_sr    <= 8'hFF;
      rx_reg   <= 8'hFF;
      bit_cnt  <= '0;
      last_bit <= 1'b0;
      div_q    <= DIVW'(DIV_SLOW);
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOW;
            tx_sr    <= wdata[6:0];
            sd_mosi  <= wdata[7];
            div_q    <= div_sel;
            bit_cnt  <= '0;
            last_bit <= 1'b0;
          end
        end
        ST_LOW: begin
          if (tick) begin
            state    <= ST_HIGH;
            sd_clk   <= 1'b1;
            rx_sr    <= {rx_sr[6:0], miso_s2};
            bit_cnt  <= bit_cnt + 3'd1;
            last_bit <= (bit_cnt == 3'd7);
          end
        end
        ST_HIGH: begin
          if (tick) begin
            sd_clk <= 1'b0;
            if (last_bit) begin
              state   <= ST_DONE;
              sd_mosi <= 1'b1;
              rx_reg  <= rx_sr;
            end else begin
              state   <= ST_LOW;
              sd_mosi <= tx_sr[6];
              tx_sr   <= {tx_sr[5:0], 1'b0};
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // A new overrun in the same cycle as a STATUS read wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_cs   <= 1'b0;
      ctrl_fast <= 1'b0;
      overrun   <= 1'b0;
      rdata     <= 8'h00;
    end else begin
      if (wr && (sel == REG_CTRL)) begin
        ctrl_cs   <= wdata[CTRL_CS];
        ctrl_fast <= wdata[CTRL_FAST];
      end
      if (wr_data && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end else if (rd && (sel == REG_STATUS)) begin
        overrun <= 1'b0;
      end
      if (rd) begin
        case (sel)
          REG_CTRL:   rdata <= {6'b0, ctrl_fast, ctrl_cs};
          REG_DATA:   rdata <= rx_reg;
          REG_STATUS: rdata <= {6'b0, overrun, busy};
          default:    rdata <= 8'hFF;
        endcase
      end
    end
  end

endmodule
